pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 46 ++++
 rtl/pipe_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath and its hazard/run controller.
// mem_req/mem_ready: a MEM-stage access completes in the cycle both are high; mem_req high with mem_ready low is a wait.
interface pipe_ctrl_if;
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic [4:0]  id_ra0;
  logic [4:0]  id_ra1;
  logic        id_re0;
  logic        id_re1;
  logic [4:0]  ex_rf_wa;
  logic        ex_rf_we;
  logic [1:0]  ex_rf_wd_sel;
  logic        ex_br_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_en;
  logic [3:0]  seg_en;
  logic [3:0]  seg_flush;
  logic [3:0]  seg_stall;
  logic [1:0]  ctrl_state;
  logic        mem_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Datapath side: raises requests and hazard info, consumes enables.
  modport master (
    output run_req, halt_req, step_req,
    output id_ra0, id_ra1, id_re0, id_re1,
    output ex_rf_wa, ex_rf_we, ex_rf_wd_sel, ex_br_taken,
    output mem_req, mem_ready,
    input  pc_en, seg_en, seg_flush, seg_stall,
    input  ctrl_state, mem_err, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  run_req, halt_req, step_req,
    input  id_ra0, id_ra1, id_re0, id_re1,
    input  ex_rf_wa, ex_rf_we, ex_rf_wd_sel, ex_br_taken,
    input  mem_req, mem_ready,
    output pc_en, seg_en, seg_flush, seg_stall,
    output ctrl_state, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline run/halt/step controller with hazard resolution (memory freeze,
// branch flush, load-use stall), memory-timeout fault and perf counters.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_HALT  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STEP  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_err_q;
  logic [31:0]       stall_cnt_q;
  logic [31:0]       flush_cnt_q;

  logic advance;
  logic mem_wait;
  logic load_use;
  logic timeout;

  logic       pc_en;
  logic [3:0] seg_en;
  logic [3:0] seg_flush;
  logic [3:0] seg_stall;

  assign advance  = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign mem_wait = advance && bus.mem_req && !bus.mem_ready;

  // r0 is hardwired zero, so a load into it never creates a dependency.
  assign load_use = (bus.ex_rf_wd_sel == 2'b10) && bus.ex_rf_we && (bus.ex_rf_wa != 5'd0) &&
                    ((bus.id_re0 && (bus.id_ra0 == bus.ex_rf_wa)) ||
                     (bus.id_re1 && (bus.id_ra1 == bus.ex_rf_wa)));

  // The MEM_TIMEOUT-th consecutive wait cycle trips the fault.
  assign timeout = mem_wait && (wait_cnt_q >= WAIT_LAST);

  always_comb begin
    pc_en     = 1'b0;
    seg_en    = 4'b0000;
    seg_flush = 4'b0000;
    seg_stall = 4'b0000;
    if (advance) begin
      seg_en = 4'b1111;
      if (mem_wait) begin
        seg_stall = 4'b1111;
      end else if (bus.ex_br_taken) begin
        pc_en     = 1'b1;
        seg_flush = 4'b0011;
      end else if (load_use) begin
        seg_stall = 4'b0001;
        seg_flush = 4'b0010;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (bus.run_req)       state_d = ST_RUN;
        else if (bus.step_req) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (timeout)           state_d = ST_FAULT;
        else if (bus.halt_req) state_d = ST_HALT;
      end
      ST_STEP: begin
        if (timeout) state_d = ST_FAULT;
        else         state_d = ST_HALT;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HALT;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= mem_wait ? wait_cnt_q + 1'b1 : '0;
      if (timeout) mem_err_q <= 1'b1;
      if (|seg_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (|seg_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.seg_en     = seg_en;
  assign bus.seg_flush  = seg_flush;
  assign bus.seg_stall  = seg_stall;
  assign bus.ctrl_state = state_q;
  assign bus.mem_err    = mem_err_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule
